seq_shift_add_multiplier: RTL
=============================

// Module: seq_shift_add_multiplier
// PURPOSE
//  Parametrised sequential unsigned multiplier: shift-and-add, one partial product per clock.
//  Generalises the combinational ripple-carry adder stage into a WIDTH x WIDTH multiplier.
//  Operand width is parametrised. Uses a start/busy/done handshake.
//  Sits in the Multiplier datapath; feeds 2*WIDTH-bit products to downstream logic.
// PARAMETERS
//  WIDTH  4  operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//  clk    in   1          rising-edge clock
//  rst_n  in   1          asynchronous reset, active low
//  start  in   1          request; sampled only in IDLE
//  A      in   WIDTH      multiplicand, captured on accepted start
//  B      in   WIDTH      multiplier, captured on accepted start
//  busy   out  1          high whenever state != IDLE
//  done   out  1          one-cycle pulse; P valid from this cycle onward
//  P      out  2*WIDTH    product register; holds until the next done
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, busy=0, done=0, P=0, all internal regs 0.
//    Mid-operation reset aborts the operation; no done pulse is emitted for it.
//  - Regs: mcand[2W-1:0], mq[W-1:0], acc[2W-1:0], cnt[$clog2(W+1)-1:0].
//  - FSM states: IDLE, RUN, DONE.
//    IDLE: start=1 at edge -> mcand={0,A}, mq=B, acc=0, cnt=0; go to RUN. Otherwise stay in IDLE.
//    RUN, each edge:
//      - if mq[0], acc += mcand (2W-bit, no overflow possible);
//      - mcand <<= 1; mq >>= 1; cnt++.
//      - Leave for DONE on the edge where cnt==WIDTH-1 (the WIDTH-th step).
//    DONE: done=1 and busy=1 for exactly one cycle; P already holds acc. Next edge -> IDLE.
//  - P is loaded with the final acc on the RUN->DONE edge; unchanged at all other times.
//  - start while busy (RUN or DONE) is ignored; A/B changes after capture have no effect.
//  - Back-to-back: earliest next accepted start is the first IDLE cycle after DONE.
//  - Latency: start sampled at edge t -> done high in the cycle after edge t+k.
//    k = number of RUN cycles; without the macro, k = WIDTH.
//  - Arithmetic is unsigned. Maximum result is (2^W-1)^2, which fits in 2W bits.
// CONFIGURATION
//  EARLY_TERM_EN defined:
//    - RUN also exits to DONE when the post-shift multiplier (mq>>1) is 0.
//    - So k = max(1, index of B's MSB set + 1); B=0 gives k=1, with P=0.
//    - Product value is identical to the default build; only latency changes.
//  EARLY_TERM_EN undefined:
//    - Fixed k = WIDTH for all operands; deterministic latency.
// TESTING (WIDTH=4)
//  1. Reset held, then released, no start -> busy=0, done=0, P=0 indefinitely.
//  2. A=13, B=11, start 1 cycle -> busy for 5 cycles, done 1-cycle pulse, P=143.
//     With EARLY_TERM_EN, same operands -> P=143, k=4.
//  3. A=15, B=15 -> P=225. A=0, B=9 -> P=0. A=7, B=0 -> P=0.
//     Without the macro, k=4 in all three cases.
//     With EARLY_TERM_EN, B=0 gives k=1 and B=1 (A=9) gives P=9, k=1.
//  4. start=1 held continuously, with A/B changed every cycle during RUN and DONE:
//     exactly one product per IDLE acceptance, computed from the captured operands.
//     Extra starts produce no extra done pulses.
//  5. rst_n pulsed low in the 2nd RUN cycle of A=5, B=6:
//     busy/done/P go to 0 immediately, no done pulse.
//     Then a fresh start with A=5, B=6 -> P=30.
//  6. Randomised sweep of all 256 A/B pairs:
//     P == A*B, done exactly once per accepted start, k matches the latency rule.

Source files
------------

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock, start/busy/done handshake.
// Optional macro EARLY_TERM_EN ends the run as soon as the remaining multiplier bits are all zero.
module seq_shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] P
);
   // state  | meaning
   // S_IDLE | waiting for start; operands captured on an accepted start
   // S_RUN  | one shift-and-add step per clock
   // S_DONE | one-cycle done pulse; P already holds the product
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] p_q;
   logic [WIDTH-1:0]   mq_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;
   logic               done_q;

   logic [2*WIDTH-1:0] acc_d;
   logic [WIDTH-1:0]   mq_d;
   logic               last_step;

   always_comb begin
      acc_d = mq_q[0] ? (acc_q + mcand_q) : acc_q;
      mq_d  = mq_q >> 1;
`ifdef EARLY_TERM_EN
      last_step = (cnt_q == CW'(WIDTH - 1)) || (mq_d == '0);
`else
      last_step = (cnt_q == CW'(WIDTH - 1));
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mcand_q <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         mq_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  mcand_q <= {{WIDTH{1'b0}}, A};
                  mq_q    <= B;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               acc_q   <= acc_d;
               mcand_q <= mcand_q << 1;
               mq_q    <= mq_d;
               cnt_q   <= cnt_q + 1'b1;
               if (last_step) begin
                  p_q     <= acc_d;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign P    = p_q;

endmodule
